// File: rtl/enc_dec_pkg.sv
// Shared definitions for the 4-to-2 priority encoder / 2-to-4 pulse decoder pair.
package enc_dec_pkg;

  localparam int CODE_W   = 2;
  localparam int ONEHOT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_t;

  // Expand an encoded index back into its one-hot line.
  function automatic logic [ONEHOT_W-1:0] decode(input logic [CODE_W-1:0] code);
    return ONEHOT_W'(1) << code;
  endfunction

endpackage

// File: rtl/down_counter_ld.sv
// Loadable down-counter with a zero flag; it saturates at zero instead of wrapping.
module down_counter_ld #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load takes priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/onehot_pulse_decoder_2to4.sv
// Sequential 2-to-4 decoder: accepts a code via valid/ready, drives a timed
// one-hot pulse for HOLD_CYCLES, then a dead-time gap of GAP_CYCLES.
module onehot_pulse_decoder_2to4
  import enc_dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CODE_W-1:0]   q,
  input  logic                v,
  output logic                ready,
  output logic [ONEHOT_W-1:0] y,
  output logic                busy,
  output logic                done
);

  // Counter wide enough for the longer of the two phases.
  localparam int CNT_W = $clog2(((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) + 1);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t            state;
  logic [CODE_W-1:0] code_reg;
  logic [CNT_W-1:0]  count;
  logic              cnt_zero;
  logic              cnt_load;
  logic              cnt_dec;
  logic [CNT_W-1:0]  cnt_load_val;

  // One counter serves both phases: loaded on entry, decremented until zero.
  down_counter_ld #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_load_val),
    .count    (count),
    .zero     (cnt_zero)
  );

  // Counter control follows the same transitions the FSM takes below.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    case (state)
      IDLE: begin
        if (v) begin
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
        end
      end
      ACTIVE: begin
        if (cnt_zero) begin
          if (GAP_CYCLES > 0) begin
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LD;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      GAP: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // FSM with registered outputs; done is set one edge early so it lines up
  // with the cycle in which ACTIVE sees counter == 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      code_reg <= '0;
      y        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ready    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (v) begin
            state    <= ACTIVE;
            code_reg <= q;
            y        <= decode(q);
            busy     <= 1'b1;
            ready    <= 1'b0;
            done     <= (HOLD_CYCLES == 1);
          end
        end
        ACTIVE: begin
          if (cnt_zero) begin
            y <= '0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              ready <= 1'b1;
            end
          end else begin
            y    <= decode(code_reg);
            done <= (count == CNT_W'(1));
          end
        end
        GAP: begin
          y <= '0;
          if (cnt_zero) begin
            state <= IDLE;
            busy  <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          y     <= '0;
          busy  <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
